damage_resolver: RTL

DAMAGE_RESOLVER -- requirements
Module: damage_resolver

---
 rtl/damage_resolver.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/damage_resolver.sv
// damage_resolver: resolves one attack at a time against two 8-bit HP pools.
//
// Flow: IDLE captures an attack; CALC registers its damage; APPLY subtracts it
// from the target with a floor at 0; CHECK pulses o_done and moves to OVER if
// the target is at 0 HP, otherwise back to IDLE. i_restart wins in every state.
//
// Ports:
//   i_clk, i_reset_n      clock (rising edge), asynchronous active-low reset
//   i_valid               attack presented (sampled only in IDLE)
//   i_state[1:0]          00 NO_HIT, 01 CRITICAL, 10 NORMAL, 11 MISS
//   i_type[1:0]           00 STANDBY, 01 LIGHT, 10 HEAVY, 11 reserved (= STANDBY)
//   i_isPlayer            1: player attacks CPU, 0: CPU attacks player
//   i_restart             synchronous new-match request
//   o_ready               high only in IDLE
//   o_done                one-cycle pulse per resolved attack
//   o_player_hp/o_cpu_hp  current HP
//   o_damage              damage of the last resolved attack
//   o_game_over/o_winner  a side reached 0 HP / 1 = player won
//
// Optional build macro HIT_COUNT_EN adds o_player_hits / o_cpu_hits, the
// saturating counts of nonzero-damage hits landed by each side.
module damage_resolver #(
    parameter logic [7:0] PLAYER_MAX_HP = 8'd100,
    parameter logic [7:0] CPU_MAX_HP    = 8'd100,
    parameter logic [7:0] LIGHT_DMG     = 8'd8,
    parameter logic [7:0] HEAVY_DMG     = 8'd15
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_valid,
    input  logic [1:0] i_state,
    input  logic [1:0] i_type,
    input  logic       i_isPlayer,
    input  logic       i_restart,
    output logic       o_ready,
    output logic       o_done,
    output logic [7:0] o_player_hp,
    output logic [7:0] o_cpu_hp,
    output logic [7:0] o_damage,
    output logic       o_game_over,
    output logic       o_winner
`ifdef HIT_COUNT_EN
    ,
    output logic [7:0] o_player_hits,
    output logic [7:0] o_cpu_hits
`endif
);

    typedef enum logic [2:0] {IDLE, CALC, APPLY, CHECK, OVER} state_t;

    state_t     state, state_nxt;
    logic [1:0] atk_state, atk_type;
    logic       atk_player;
    logic [7:0] dmg_q;
    logic [7:0] base_dmg, calc_dmg;
    logic [8:0] dbl_dmg;
    logic [7:0] target_hp, target_after;
    logic       target_zero;

    // Damage from the captured attack
    always_comb begin
        base_dmg = 8'd0;
        case (atk_type)
            2'b01:   base_dmg = LIGHT_DMG;
            2'b10:   base_dmg = HEAVY_DMG;
            default: base_dmg = 8'd0;
        endcase
        dbl_dmg  = {base_dmg, 1'b0};
        calc_dmg = 8'd0;
        case (atk_state)
            2'b10:   calc_dmg = base_dmg;
            2'b01:   calc_dmg = dbl_dmg[8] ? 8'hFF : dbl_dmg[7:0];
            default: calc_dmg = 8'd0;
        endcase
    end

    // Target is the side that did not attack
    always_comb begin
        target_hp    = atk_player ? o_cpu_hp : o_player_hp;
        target_after = (target_hp >= dmg_q) ? (target_hp - dmg_q) : 8'd0;
        target_zero  = (target_hp == 8'd0);
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (i_restart) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_valid) state_nxt = CALC;
                CALC:    state_nxt = APPLY;
                APPLY:   state_nxt = CHECK;
                CHECK:   state_nxt = target_zero ? OVER : IDLE;
                OVER:    state_nxt = OVER;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        o_ready = (state == IDLE);
    end

    // Datapath
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            atk_state   <= 2'b00;
            atk_type    <= 2'b00;
            atk_player  <= 1'b0;
            dmg_q       <= 8'd0;
            o_player_hp <= PLAYER_MAX_HP;
            o_cpu_hp    <= CPU_MAX_HP;
            o_damage    <= 8'd0;
            o_done      <= 1'b0;
            o_game_over <= 1'b0;
            o_winner    <= 1'b0;
        end else if (i_restart) begin
            // Any in-flight attack is dropped here, so no o_done follows
            dmg_q       <= 8'd0;
            o_player_hp <= PLAYER_MAX_HP;
            o_cpu_hp    <= CPU_MAX_HP;
            o_damage    <= 8'd0;
            o_done      <= 1'b0;
            o_game_over <= 1'b0;
            o_winner    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        atk_state  <= i_state;
                        atk_type   <= i_type;
                        atk_player <= i_isPlayer;
                    end
                end
                CALC: dmg_q <= calc_dmg;
                APPLY: begin
                    if (atk_player) o_cpu_hp    <= target_after;
                    else            o_player_hp <= target_after;
                    o_damage <= dmg_q;
                end
                CHECK: begin
                    o_done <= 1'b1;
                    if (target_zero) begin
                        o_game_over <= 1'b1;
                        o_winner    <= atk_player;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef HIT_COUNT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_player_hits <= 8'd0;
            o_cpu_hits    <= 8'd0;
        end else if (i_restart) begin
            o_player_hits <= 8'd0;
            o_cpu_hits    <= 8'd0;
        end else if (state == APPLY && dmg_q != 8'd0) begin
            if (atk_player) begin
                if (o_player_hits != 8'hFF) o_player_hits <= o_player_hits + 8'd1;
            end else begin
                if (o_cpu_hits != 8'hFF) o_cpu_hits <= o_cpu_hits + 8'd1;
            end
        end
    end
`endif

endmodule
